// File: rtl/vram_blitter_if.sv
// Bus bundle for vram_blitter: register window, CPU VRAM path and VRAM port A.
// The slave side is the blitter; the master side is the CPU/VRAM environment.
interface vram_blitter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          cs;
    logic          rw;
    logic [2:0]    AD;
    logic [DW-1:0] DI;
    logic [DW-1:0] DO;
    logic          irq;
    logic          busy;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cs, rw, AD, DI,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output DO, irq, busy,
        output cpu_ack, cpu_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cs, rw, AD, DI,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  DO, irq, busy,
        input  cpu_ack, cpu_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/vram_blitter.sv
// VRAM block fill/copy engine sharing port A with the CPU (CPU has priority).
// Register window at AD[2:0]; level irq on completion when enabled.
module vram_blitter #(
    parameter int AW = 13,
    parameter int DW = 8,
    parameter int CW = 14
) (
    input  logic          clk,
    input  logic          rst,
    vram_blitter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic          mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          ien_q, ien_d;
    logic          done_q, done_d;

    logic          busy;
    logic          reg_we;
    logic          ctrl_wr;
    logic          ctrl_rd;
    logic          abort;
    logic          stall;
    logic          eng_we;
    logic [AW-1:0] src_nx;
    logic [AW-1:0] dst_nx;

    assign busy    = (state_q != IDLE);
    assign reg_we  = bus.cs & ~bus.rw;
    assign ctrl_wr = reg_we & (bus.AD == 3'd7);
    assign ctrl_rd = bus.cs & bus.rw & (bus.AD == 3'd7);
    assign abort   = ctrl_wr & bus.DI[7];
    assign stall   = bus.cpu_req;
    assign src_nx  = dir_q ? src_q - AW'(1) : src_q + AW'(1);
    assign dst_nx  = dir_q ? dst_q - AW'(1) : dst_q + AW'(1);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        data_d  = data_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        ien_d   = ien_q;
        done_d  = done_q;

        if (ctrl_rd) done_d = 1'b0;

        if (reg_we && !busy) begin
            unique case (bus.AD)
                3'd0: src_d  = {bus.DI[AW-9:0], src_q[7:0]};
                3'd1: src_d  = {src_q[AW-1:8], bus.DI};
                3'd2: dst_d  = {bus.DI[AW-9:0], dst_q[7:0]};
                3'd3: dst_d  = {dst_q[AW-1:8], bus.DI};
                3'd4: cnt_d  = {bus.DI[CW-9:0], cnt_q[7:0]};
                3'd5: cnt_d  = {cnt_q[CW-1:8], bus.DI};
                3'd6: fill_d = bus.DI;
                3'd7: begin
                    mode_d = bus.DI[1];
                    dir_d  = bus.DI[2];
                    ien_d  = bus.DI[6];
                end
            endcase
        end else if (ctrl_wr) begin
            ien_d = bus.DI[6];
        end

        // Abort beats both START and any pending step this cycle.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (ctrl_wr && bus.DI[0]) begin
                    if (cnt_q == '0) done_d  = 1'b1;
                    else             state_d = bus.DI[1] ? RD : WR;
                end
                RD: if (!stall) state_d = RDW;
                RDW: begin
                    data_d  = bus.mem_rdata;
                    state_d = WR;
                end
                WR: if (!stall) begin
                    cnt_d = cnt_q - CW'(1);
                    dst_d = dst_nx;
                    if (mode_q) src_d = src_nx;
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = mode_q ? RD : WR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            ien_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            done_q  <= done_d;
        end
    end

    // An abort landing on a WR cycle must not commit that byte.
    assign eng_we = (state_q == WR) & ~abort;

    always_comb begin
        bus.mem_addr  = (state_q == RD) ? src_q : dst_q;
        bus.mem_wdata = mode_q ? data_q : fill_q;
        bus.mem_we    = eng_we;
        if (bus.cpu_req) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_we;
        end
    end

    always_comb begin
        bus.DO = '0;
        unique case (bus.AD)
            3'd0: bus.DO = DW'(src_q >> 8);
            3'd1: bus.DO = src_q[7:0];
            3'd2: bus.DO = DW'(dst_q >> 8);
            3'd3: bus.DO = dst_q[7:0];
            3'd4: bus.DO = DW'(cnt_q >> 8);
            3'd5: bus.DO = cnt_q[7:0];
            3'd6: bus.DO = fill_q;
            3'd7: bus.DO = {done_q, ien_q, 3'b000, dir_q, mode_q, busy};
        endcase
    end

    assign bus.irq       = done_q & ien_q;
    assign bus.busy      = busy;
    assign bus.cpu_ack   = bus.cpu_req;
    assign bus.cpu_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_vram_blitter.sv
// Directed bench for vram_blitter: register vectors plus fill/copy/contention,
// wrap, zero-count, abort and reset sequences against a VRAM model.
module tb_vram_blitter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    vram_blitter_if bus ();

    vram_blitter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        log_q[$];
    logic [7:0] vram [0:8191];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.mem_rdata <= vram[bus.mem_addr];
        if (bus.mem_we) begin
            vram[bus.mem_addr] <= bus.mem_wdata;
            log_q.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
        end
    end

    typedef struct {
        logic [2:0] ad;
        logic [7:0] di;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.cs = 1'b1;
        bus.rw = 1'b0;
        bus.AD = a;
        bus.DI = d;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        bus.cs = 1'b1;
        bus.rw = 1'b1;
        bus.AD = a;
        #1 v = bus.DO;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic cpu_acc(input logic we, input logic [12:0] a,
                           input logic [7:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.busy), 0);
    endtask

    task automatic setup(input logic [12:0] s, input logic [12:0] d,
                         input logic [13:0] c, input logic [7:0] f);
        wr(3'd0, 8'(s >> 8));
        wr(3'd1, s[7:0]);
        wr(3'd2, 8'(d >> 8));
        wr(3'd3, d[7:0]);
        wr(3'd4, 8'(c >> 8));
        wr(3'd5, c[7:0]);
        wr(3'd6, f);
    endtask

    logic [7:0] v;
    int         t0;
    int         n;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        bus.cs = 1'b0;
        bus.rw = 1'b1;
        bus.AD = '0;
        bus.DI = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        rst = 1'b0;

        vt[0] = '{3'd0, 8'hFF, 8'h1F};
        vt[1] = '{3'd1, 8'hAB, 8'hAB};
        vt[2] = '{3'd2, 8'hE3, 8'h03};
        vt[3] = '{3'd3, 8'h5C, 8'h5C};
        vt[4] = '{3'd4, 8'hFF, 8'h3F};
        vt[5] = '{3'd5, 8'h00, 8'h00};
        vt[6] = '{3'd6, 8'h96, 8'h96};
        vt[7] = '{3'd7, 8'h46, 8'h46};
        vt[8] = '{3'd7, 8'h00, 8'h00};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        chk("rst_irq", int'(bus.irq), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_we", int'(bus.mem_we), 0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("rst_reg%0d", i), int'(v), 0);
        end

        for (int i = 0; i < 9; i++) begin
            wr(vt[i].ad, vt[i].di);
            rd(vt[i].ad, v);
            chk($sformatf("vec%0d", i), int'(v), int'(vt[i].exp));
        end

        // Fill 4 bytes at 0x100
        setup(13'h0, 13'h0100, 14'd4, 8'hA5);
        log_q.delete();
        wr(3'd7, 8'h01);
        t0 = cyc;
        wait_idle("fill_to");
        chk("fill_n", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("fill_a", int'(log_q[i].a), 'h100 + i);
            chk("fill_d", int'(log_q[i].d), 'hA5);
            chk("fill_t", log_q[i].cyc, t0 + i);
        end
        rd(3'd7, v); chk("fill_ctrl", int'(v), 'h80);
        rd(3'd7, v); chk("fill_dclr", int'(v), 'h00);
        rd(3'd2, v); chk("fill_dsth", int'(v), 'h01);
        rd(3'd3, v); chk("fill_dstl", int'(v), 'h04);
        rd(3'd5, v); chk("fill_cnt", int'(v), 'h00);

        // Copy 3 bytes, decrementing
        cpu_acc(1'b1, 13'h20, 8'h11);
        cpu_acc(1'b1, 13'h21, 8'h22);
        cpu_acc(1'b1, 13'h22, 8'h33);
        setup(13'h22, 13'h52, 14'd3, 8'h00);
        log_q.delete();
        wr(3'd7, 8'h07);
        t0 = cyc;
        wait_idle("copy_to");
        chk("copy_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("copy_a0", int'(log_q[0].a), 'h52);
            chk("copy_a2", int'(log_q[2].a), 'h50);
            chk("copy_t", log_q[2].cyc, t0 + 8);
        end
        for (int i = 0; i < 3; i++) begin
            cpu_acc(1'b0, 13'(16'h50 + i), 8'h00);
            chk("copy_rd", int'(bus.cpu_rdata), 'h11 * (i + 1));
        end
        rd(3'd7, v); chk("copy_ctrl", int'(v), 'h86);
        rd(3'd1, v); chk("copy_src", int'(v), 'h1F);

        // Fill 8 with 3 cycles of CPU contention
        setup(13'h0, 13'h0200, 14'd8, 8'h3C);
        log_q.delete();
        wr(3'd7, 8'h01);
        t0 = cyc;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 13'(16'h1000 + k);
            bus.cpu_wdata = 8'(8'hC0 + k);
            #1;
            chk("cont_ack", int'(bus.cpu_ack), 1);
            chk("cont_addr", int'(bus.mem_addr), 'h1000 + k);
            chk("cont_wd", int'(bus.mem_wdata), 'hC0 + k);
            @(negedge clk);
        end
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        wait_idle("cont_to");
        chk("cont_n", log_q.size(), 11);
        n = 0;
        foreach (log_q[i]) begin
            if (log_q[i].a >= 13'h200 && log_q[i].a < 13'h208) begin
                chk("cont_seq", int'(log_q[i].a), 'h200 + n);
                n++;
            end
        end
        chk("cont_eng", n, 8);
        if (log_q.size() == 11)
            chk("cont_t", log_q[10].cyc, t0 + 10);
        rd(3'd7, v);

        // Increment fill across the top of VRAM
        setup(13'h0, 13'h1FFE, 14'd4, 8'h77);
        log_q.delete();
        wr(3'd7, 8'h01);
        wait_idle("wrap_to");
        chk("wrap_n", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk("wrap_a", int'(log_q[i].a), ('h1FFE + i) % 'h2000);
        rd(3'd2, v); chk("wrap_dsth", int'(v), 'h00);
        rd(3'd3, v); chk("wrap_dstl", int'(v), 'h02);
        rd(3'd7, v);

        // Zero count with IEN
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h00);
        log_q.delete();
        chk("z_irq0", int'(bus.irq), 0);
        wr(3'd7, 8'h41);
        chk("z_irq", int'(bus.irq), 1);
        chk("z_busy", int'(bus.busy), 0);
        chk("z_nowr", log_q.size(), 0);
        rd(3'd7, v); chk("z_ctrl", int'(v), 'hC0);
        chk("z_irqclr", int'(bus.irq), 0);
        wr(3'd7, 8'h00);

        // Abort after 2 of 10
        setup(13'h0, 13'h0300, 14'd10, 8'h5A);
        log_q.delete();
        wr(3'd7, 8'h01);
        repeat (2) @(negedge clk);
        wr(3'd7, 8'h80);
        chk("ab_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        chk("ab_n", log_q.size(), 2);
        rd(3'd5, v); chk("ab_cnt", int'(v), 8);
        rd(3'd3, v); chk("ab_dst", int'(v), 'h02);
        rd(3'd7, v); chk("ab_ctrl", int'(v), 'h80);

        // Reset in the middle of a copy
        setup(13'h20, 13'h60, 14'd3, 8'hEE);
        log_q.delete();
        wr(3'd7, 8'h03);
        repeat (2) @(negedge clk);
        chk("rs_we1", int'(bus.mem_we), 1);
        rst = 1'b0;
        #1;
        chk("rs_we0", int'(bus.mem_we), 0);
        chk("rs_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_nowr", log_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("rs_reg%0d", i), int'(v), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
